// File: rtl/seg7_scan_pkg.sv
// rtl/seg7_scan_pkg.sv - shared types and word-building helpers for the 7-segment scan scheduler
//
// Purpose: scheduler state encoding, serial word construction and the
// enabled-digit priority search used by seg7_scan_scheduler.
// Ports: none (package).
package seg7_scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEND  = 3'd1,
    ST_DWELL = 3'd2,
    ST_BLANK = 3'd3,
    ST_NEXT  = 3'd4
  } scan_state_t;

  // All segments off in the active-low segment byte.
  localparam logic [7:0] BLANK_SEG = 8'hFF;

  // {one-hot digit select in [15:12] (digit 0 on bit 15), fill, active-low segments}.
  // The dot is ORed into segment h, which sits on bit 0 of the segment byte.
  function automatic logic [15:0] build_word(input logic [7:0] seg8, input logic dot,
                                             input logic [1:0] idx, input logic [3:0] fill);
    logic [3:0] sel;
    sel = 4'b1000 >> idx;
    return {sel, fill, ~{seg8[7:1], seg8[0] | dot}};
  endfunction

  function automatic logic [15:0] blank_word(input logic [3:0] fill);
    return {4'b0000, fill, BLANK_SEG};
  endfunction

  // Lowest set index of mask; 0 when mask is empty (callers gate on |mask).
  function automatic logic [1:0] first_enabled(input logic [3:0] mask);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i]) r = 2'(i);
    end
    return r;
  endfunction

  // {found, index} of the lowest set bit of mask strictly above idx.
  function automatic logic [2:0] next_enabled(input logic [3:0] mask, input logic [1:0] idx);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i] && (i > int'(idx))) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_scan_scheduler.sv
// rtl/seg7_scan_scheduler.sv - per-frame digit scan scheduler feeding the shift-register display driver
//
// Purpose: snapshots segment/dot/enable inputs once per frame, then for each
// enabled digit offers its 16-bit word over valid/ready, holds it lit for
// DWELL_CYCLES, and optionally follows it with a blanking word.
// Ports:
//   clk           scheduler clock
//   rst_n_i       asynchronous active-low reset
//   en_i          scanning enable
//   digit_en_i    per-digit enable mask (bit k = digit k)
//   seg_i         digit k segments at [8k+7:8k], {a..g,h}, active-high
//   dot_i         per-digit dot, ORed into segment h
//   data_o        word offered to the driver
//   valid_o       data_o valid
//   ready_i       driver accepts data_o on an edge with valid_o && ready_i
//   cur_digit_o   index of the digit currently lit
//   frame_done_o  one-cycle pulse at end of frame
module seg7_scan_scheduler
  import seg7_scan_pkg::*;
#(
  parameter int         DWELL_CYCLES = 1000,
  parameter bit         BLANK_EN     = 1'b1,
  parameter logic [3:0] FILL_NIBBLE  = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n_i,
  input  logic        en_i,
  input  logic [3:0]  digit_en_i,
  input  logic [31:0] seg_i,
  input  logic [3:0]  dot_i,
  output logic [15:0] data_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [1:0]  cur_digit_o,
  output logic        frame_done_o
);

  localparam int               CNT_W      = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [15:0]      BLANK_WORD = blank_word(FILL_NIBBLE);

  generate
    if (DWELL_CYCLES < 1) begin : g_bad_dwell
      $error("seg7_scan_scheduler: DWELL_CYCLES must be >= 1");
    end
  endgenerate

  scan_state_t      state_q, state_d;
  logic             valid_q, valid_d;
  logic [15:0]      data_q, data_d;
  logic [1:0]       cur_digit_q, cur_digit_d;
  logic             frame_done_q, frame_done_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      seg_sh_q, seg_sh_d;
  logic [3:0]       dot_sh_q, dot_sh_d;
  logic [3:0]       den_sh_q, den_sh_d;

  logic [1:0]  first_idx;
  logic [2:0]  nxt;
  logic [15:0] idle_word;
  logic [15:0] next_word;

  // The IDLE word is built from the live inputs because the shadow registers
  // are being loaded on the same edge; later words come from the shadow copy.
  assign first_idx = first_enabled(digit_en_i);
  assign nxt       = next_enabled(den_sh_q, idx_q);
  assign idle_word = build_word(seg_i[{first_idx, 3'b000} +: 8], dot_i[first_idx],
                                first_idx, FILL_NIBBLE);
  assign next_word = build_word(seg_sh_q[{nxt[1:0], 3'b000} +: 8], dot_sh_q[nxt[1:0]],
                                nxt[1:0], FILL_NIBBLE);

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    data_d       = data_q;
    cur_digit_d  = cur_digit_q;
    frame_done_d = 1'b0;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    seg_sh_d     = seg_sh_q;
    dot_sh_d     = dot_sh_q;
    den_sh_d     = den_sh_q;

    case (state_q)
      ST_IDLE: begin
        if (en_i && (|digit_en_i)) begin
          seg_sh_d = seg_i;
          dot_sh_d = dot_i;
          den_sh_d = digit_en_i;
          idx_d    = first_idx;
          data_d   = idle_word;
          valid_d  = 1'b1;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        if (ready_i) begin
          valid_d     = 1'b0;
          cur_digit_d = idx_q;
          cnt_d       = CNT_LOAD;
          state_d     = ST_DWELL;
        end
      end
      ST_DWELL: begin
        if (cnt_q == '0) begin
          // A disabled scanner always leaves the display dark before idling.
          if (BLANK_EN || !en_i) begin
            data_d  = BLANK_WORD;
            valid_d = 1'b1;
            state_d = ST_BLANK;
          end else begin
            state_d = ST_NEXT;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_BLANK: begin
        if (ready_i) begin
          valid_d = 1'b0;
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (nxt[2] && en_i) begin
          idx_d   = nxt[1:0];
          data_d  = next_word;
          valid_d = 1'b1;
          state_d = ST_SEND;
        end else begin
          frame_done_d = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      valid_q      <= 1'b0;
      data_q       <= BLANK_WORD;
      cur_digit_q  <= 2'd0;
      frame_done_q <= 1'b0;
      idx_q        <= 2'd0;
      cnt_q        <= '0;
      seg_sh_q     <= '0;
      dot_sh_q     <= '0;
      den_sh_q     <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      cur_digit_q  <= cur_digit_d;
      frame_done_q <= frame_done_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      seg_sh_q     <= seg_sh_d;
      dot_sh_q     <= dot_sh_d;
      den_sh_q     <= den_sh_d;
    end
  end

  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign cur_digit_o  = cur_digit_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_scheduler.sv
// tb/tb_seg7_scan_scheduler.sv - self-checking bench for seg7_scan_scheduler
module tb_seg7_scan_scheduler;

  localparam int DW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        en    [2];
  logic [3:0]  den   [2];
  logic [31:0] seg   [2];
  logic [3:0]  dot   [2];
  logic        ready [2];
  logic [15:0] data  [2];
  logic        valid [2];
  logic [1:0]  cur   [2];
  logic        fd    [2];

  // Instance 0 blanks between digits, instance 1 does not.
  seg7_scan_scheduler #(.DWELL_CYCLES(DW), .BLANK_EN(1'b1), .FILL_NIBBLE(4'hF)) u_dut_blank (
    .clk(clk), .rst_n_i(rst_n), .en_i(en[0]), .digit_en_i(den[0]), .seg_i(seg[0]),
    .dot_i(dot[0]), .data_o(data[0]), .valid_o(valid[0]), .ready_i(ready[0]),
    .cur_digit_o(cur[0]), .frame_done_o(fd[0])
  );

  seg7_scan_scheduler #(.DWELL_CYCLES(DW), .BLANK_EN(1'b0), .FILL_NIBBLE(4'hF)) u_dut_noblank (
    .clk(clk), .rst_n_i(rst_n), .en_i(en[1]), .digit_en_i(den[1]), .seg_i(seg[1]),
    .dot_i(dot[1]), .data_o(data[1]), .valid_o(valid[1]), .ready_i(ready[1]),
    .cur_digit_o(cur[1]), .frame_done_o(fd[1])
  );

  int checks = 0;
  int passes = 0;
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  int fd_cnt [2] = '{0, 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push(input int sel, input logic [15:0] w);
    if (sel == 0) q0.push_back(w);
    else q1.push_back(w);
  endtask

  function automatic int qsize(input int sel);
    return (sel == 0) ? q0.size() : q1.size();
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted word must match the head of that instance's queue.
  always @(negedge clk) begin
    logic [15:0] e;
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (fd[i]) fd_cnt[i]++;
        if (valid[i] && ready[i]) begin
          if (qsize(i) == 0) begin
            checks++;
            $display("FAIL extra_word_dut%0d: got %h expected none", i, data[i]);
          end else begin
            if (i == 0) e = q0.pop_front();
            else e = q1.pop_front();
            check($sformatf("word_dut%0d", i), 32'(data[i]), 32'(e));
          end
        end
      end
    end
  end

  // Waits for frame_done and drops en in that IDLE cycle so no new frame starts.
  task automatic wait_frame(input int sel, input int budget);
    int  n;
    bit  got;
    n   = 0;
    got = 1'b0;
    while (!got && n < budget) begin
      @(negedge clk);
      n++;
      if (fd[sel]) begin
        got      = 1'b1;
        en[sel]  = 1'b0;
      end
    end
    if (!got) begin
      checks++;
      $display("FAIL frame_timeout_dut%0d: got no frame_done expected one within %0d cycles", sel, budget);
      en[sel] = 1'b0;
    end
  endtask

  task automatic wait_qsize(input int sel, input int target, input int budget);
    int n;
    n = 0;
    while (qsize(sel) > target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (qsize(sel) > target) begin
      checks++;
      $display("FAIL accept_timeout_dut%0d: got queue %0d expected %0d", sel, qsize(sel), target);
    end
  endtask

  task automatic wait_valid(input int sel, input int budget);
    int n;
    n = 0;
    while (!valid[sel] && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!valid[sel]) begin
      checks++;
      $display("FAIL valid_timeout_dut%0d: got valid 0 expected 1", sel);
    end
  endtask

  task automatic post_frame(input int sel, input int f0, input logic [1:0] last);
    repeat (3) sync();
    check("frame_done_once", 32'(fd_cnt[sel] - f0), 32'd1);
    check("words_left", 32'(qsize(sel)), 32'd0);
    check("cur_digit", 32'(cur[sel]), 32'(last));
  endtask

  typedef struct {
    int              sel;
    logic [3:0]      den;
    logic [31:0]     seg;
    logic [3:0]      dot;
    int              n;
    logic [7:0][15:0] w;   // w[0] is the first word accepted
    logic [1:0]      last;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int f0;

    tbl[0] = '{0, 4'hF, 32'h3F06_5B4F, 4'h0, 8,
               {16'h0FFF, 16'h1FC0, 16'h0FFF, 16'h2FF9, 16'h0FFF, 16'h4FA4, 16'h0FFF, 16'h8FB0}, 2'd3};
    tbl[1] = '{1, 4'b0101, 32'h1200_0080, 4'b0100, 2,
               {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h2FFE, 16'h8F7F}, 2'd2};
    tbl[2] = '{0, 4'b1000, 32'hFF00_0000, 4'b1000, 2,
               {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0FFF, 16'h1F00}, 2'd3};
    tbl[3] = '{1, 4'b0110, 32'h006D_7D00, 4'b0010, 2,
               {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h2F92, 16'h4F82}, 2'd2};
    tbl[4] = '{0, 4'b0000, 32'h1234_5678, 4'hF, 0, '0, 2'd0};

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      en[i] = 1'b0; den[i] = 4'h0; seg[i] = '0; dot[i] = 4'h0; ready[i] = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_valid_dut%0d", i), 32'(valid[i]), 32'd0);
      check($sformatf("rst_data_dut%0d", i), 32'(data[i]), 32'h0FFF);
      check($sformatf("rst_cur_dut%0d", i), 32'(cur[i]), 32'd0);
      check($sformatf("rst_fd_dut%0d", i), 32'(fd[i]), 32'd0);
    end
    sync();
    rst_n = 1'b1;
    repeat (2) sync();

    // Table-driven frames.
    for (int v = 0; v < 5; v++) begin
      int s;
      s = tbl[v].sel;
      sync();
      den[s] = tbl[v].den; seg[s] = tbl[v].seg; dot[s] = tbl[v].dot;
      for (int j = 0; j < tbl[v].n; j++) push(s, tbl[v].w[j]);
      f0 = fd_cnt[s];
      en[s] = 1'b1;
      if (tbl[v].n == 0) begin
        repeat (20) sync();
        en[s] = 1'b0;
        check("empty_mask_no_frame", 32'(fd_cnt[s] - f0), 32'd0);
        check("empty_mask_valid", 32'(valid[s]), 32'd0);
      end else begin
        wait_frame(s, 200);
        post_frame(s, f0, tbl[v].last);
      end
    end

    // Back-pressure: word held stable while ready is low, accepted once.
    sync();
    den[0] = 4'b0010; seg[0] = 32'h0000_7700; dot[0] = 4'h0; ready[0] = 1'b0;
    f0 = fd_cnt[0];
    en[0] = 1'b1;
    wait_valid(0, 20);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_valid", 32'(valid[0]), 32'd1);
      check("stall_data", 32'(data[0]), 32'h4F88);
    end
    sync();
    push(0, 16'h4F88); push(0, 16'h0FFF);
    ready[0] = 1'b1;
    wait_frame(0, 200);
    post_frame(0, f0, 2'd1);

    // Mid-frame seg change only shows up in the following frame.
    sync();
    den[0] = 4'b0011; seg[0] = 32'h0000_0606; dot[0] = 4'h0;
    push(0, 16'h8FF9); push(0, 16'h0FFF); push(0, 16'h4FF9); push(0, 16'h0FFF);
    f0 = fd_cnt[0];
    en[0] = 1'b1;
    wait_qsize(0, 3, 50);
    seg[0] = 32'h0000_3F3F;
    wait_frame(0, 200);
    post_frame(0, f0, 2'd1);
    push(0, 16'h8FC0); push(0, 16'h0FFF); push(0, 16'h4FC0); push(0, 16'h0FFF);
    f0 = fd_cnt[0];
    en[0] = 1'b1;
    wait_frame(0, 200);
    post_frame(0, f0, 2'd1);

    // en dropped during digit 1 dwell without blanking: forced blank, then idle.
    sync();
    den[1] = 4'hF; seg[1] = 32'h0000_5B4F; dot[1] = 4'h0; ready[1] = 1'b1;
    push(1, 16'h8FB0); push(1, 16'h4FA4); push(1, 16'h0FFF);
    f0 = fd_cnt[1];
    en[1] = 1'b1;
    wait_qsize(1, 1, 50);
    sync();
    en[1] = 1'b0;
    wait_frame(1, 200);
    repeat (20) sync();
    check("en_drop_words_left", 32'(qsize(1)), 32'd0);
    check("en_drop_frame_once", 32'(fd_cnt[1] - f0), 32'd1);
    check("en_drop_idle_valid", 32'(valid[1]), 32'd0);

    // Asynchronous reset while a word is pending.
    sync();
    ready[0] = 1'b0; den[0] = 4'b0110; seg[0] = 32'h0000_0600; dot[0] = 4'h0;
    en[0] = 1'b1;
    wait_valid(0, 20);
    check("pre_reset_word", 32'(data[0]), 32'h4FF9);
    #2 rst_n = 1'b0;
    #1;
    check("reset_valid_drop", 32'(valid[0]), 32'd0);
    check("reset_data_blank", 32'(data[0]), 32'h0FFF);
    sync();
    push(0, 16'h4FF9); push(0, 16'h0FFF); push(0, 16'h2FFF); push(0, 16'h0FFF);
    f0 = fd_cnt[0];
    ready[0] = 1'b1;
    rst_n = 1'b1;
    wait_frame(0, 200);
    post_frame(0, f0, 2'd2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
